mem_bus_arbiter: RTL and testbench

Shares the single-port Memory block (CS/WE/7-bit ADDR/32-bit bidirectional Mem_Bus) between two requesters: port 0 (MIPS CPU) and port 1 (loader/debug/DMA agent).
- Each requester has a separate-data req/ack interface.
- The arbiter alone drives the Memory-side pins and bus, one transaction at a time.
- Sits between CPU/agent and Memory inside Complete_MIPS.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory bus arbiter.
//   - state_e   : arbiter FSM encoding (IDLE / ACC / RESP)
//   - P0 / P1   : requester port indices
//   - ADDR_W_DEF / DATA_W_DEF : default memory geometry
//   - sat_inc16 : saturating 16-bit increment used by the grant counters
// Optional feature macro referenced by users of this package: MEM_ARB_STATS_EN
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Purely combinational two-way request picker.
// Ports:
//   req0_i, req1_i  : pending requests from port 0 / port 1
//   last_i          : index of the port granted most recently
//   rr_i            : 1 = round-robin on a tie, 0 = port 0 always wins a tie
//   grant_valid_o   : at least one request is pending
//   grant_idx_o     : index of the port to serve (meaningful when grant_valid_o)
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic rr_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves it unassigned (which would infer a latch).
  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_idx_o   = P0;
    if (req0_i && req1_i) begin
      // On a tie, round-robin hands the bus to whoever did not have it last.
      grant_idx_o = rr_i ? ~last_i : P0;
    end else if (req1_i) begin
      grant_idx_o = P1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port memory (CS / WE / ADDR / bidirectional data bus)
// between two requesters with independent req/ack interfaces. One access is
// in flight at a time: IDLE (pick + latch command) -> ACC (memory cycle,
// memory samples on the mid-cycle negedge) -> RESP (one-cycle ack) -> IDLE.
//
// Parameters:
//   ADDR_W : memory word-address width
//   DATA_W : data / bus width
//   RR     : 1 = round-robin on a tie, 0 = fixed priority (port 0 wins)
// Ports:
//   CLK, RST                      : clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0         : port 0 command (req held until ack0)
//   ack0, rdata0                  : port 0 completion pulse, read data
//   req1/we1/addr1/wdata1         : port 1 command (req held until ack1)
//   ack1, rdata1                  : port 1 completion pulse, read data
//   MEM_CS, MEM_WE, MEM_ADDR      : memory control pins (idle = 0 outside ACC)
//   MEM_BUS                       : memory data bus, driven only on ACC writes
//   gcnt0, gcnt1                  : per-port saturating grant counters
//
// Optional feature: define MEM_ARB_STATS_EN to build the grant counters;
// without it gcnt0/gcnt1 read as zero and the port list is unchanged.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RR     = 1
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,

  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  inout  wire  [DATA_W-1:0] MEM_BUS,

  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
);

  // ---------------------------------------------------------------------------
  // State and latched command
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                last_q;
  logic                idx_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                grant_valid;
  logic                grant_idx;
  logic                grant_take;
  logic                bus_oe;

  // Selected command from the winning port, captured only on a grant.
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  mem_arb_pick u_pick (
    .req0_i        (req0),
    .req1_i        (req1),
    .last_i        (last_q),
    .rr_i          (RR != 0),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Requests are only looked at in IDLE; anything raised during ACC/RESP
  // waits for the next IDLE cycle.
  assign grant_take = (state_q == IDLE) && grant_valid;

  assign sel_we    = (grant_idx == P1) ? we1    : we0;
  assign sel_addr  = (grant_idx == P1) ? addr1  : addr0;
  assign sel_wdata = (grant_idx == P1) ? wdata1 : wdata0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples values from before the clock edge, independent of the
  // order the always blocks are evaluated in.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACC;
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (memory pins, bus enable, acks)
  // Outputs decode the registered state, so an asynchronous reset drops CS,
  // WE, ADDR and releases the bus in the same instant.
  // ---------------------------------------------------------------------------
  always_comb begin
    MEM_CS   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    bus_oe   = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    unique case (state_q)
      ACC: begin
        MEM_CS   = 1'b1;
        MEM_WE   = we_q;
        MEM_ADDR = addr_q;
        bus_oe   = we_q;
      end
      RESP: begin
        ack0 = (idx_q == P0);
        ack1 = (idx_q == P1);
      end
      default: ;
    endcase
  end

  // The arbiter drives the shared bus only while writing; reads leave it
  // to the memory.
  assign MEM_BUS = bus_oe ? wdata_q : {DATA_W{1'bz}};

  // ---------------------------------------------------------------------------
  // Command latch, tie-break history and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_q   <= P1;            // so port 0 wins the first tie after reset
      idx_q    <= P0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant_take) begin
        idx_q   <= grant_idx;
        last_q  <= grant_idx;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      // Memory presents read data after the mid-cycle negedge; it is stable
      // by the posedge that closes ACC.
      if ((state_q == ACC) && !we_q) begin
        if (idx_q == P0) begin
          rdata0_q <= MEM_BUS;
        end else begin
          rdata1_q <= MEM_BUS;
        end
      end
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // ---------------------------------------------------------------------------
  // Optional grant counters
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STATS_EN
  logic [15:0] gcnt0_q;
  logic [15:0] gcnt1_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else if (grant_take) begin
      if (grant_idx == P0) begin
        gcnt0_q <= sat_inc16(gcnt0_q);
      end else begin
        gcnt1_q <= sat_inc16(gcnt1_q);
      end
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`else
  assign gcnt0 = 16'd0;
  assign gcnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiter instances: dut_a (round-robin) with a behavioural memory that
// writes on the negedge and drives reads combinationally, and dut_b (fixed
// priority) whose memory returns the address as read data. A table of
// single-port transactions exercises dut_a; hand-written sequences cover the
// tie from reset, round-robin fairness, fixed priority, and reset during ACC.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- instance A (RR = 1) ----------------
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_bus;
  logic [15:0]   gcnt0, gcnt1;

  logic [DW-1:0] ram [0:127];
  logic          tb_drv;
  logic [DW-1:0] tb_drv_val;

  assign mem_bus = (mem_cs && !mem_we) ? ram[mem_addr] : {DW{1'bz}};
  assign mem_bus = tb_drv ? tb_drv_val : {DW{1'bz}};
  always @(negedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_bus;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) dut_a (
    .CLK(clk), .RST(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .MEM_CS(mem_cs), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_BUS(mem_bus),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  // ---------------- instance B (RR = 0) ----------------
  logic          b_req0, b_we0, b_req1, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_ack0, b_ack1;
  logic [DW-1:0] b_rdata0, b_rdata1;
  logic          b_mem_cs, b_mem_we;
  logic [AW-1:0] b_mem_addr;
  wire  [DW-1:0] b_mem_bus;
  logic [15:0]   b_gcnt0, b_gcnt1;

  assign b_mem_bus = (b_mem_cs && !b_mem_we) ? {{(DW-AW){1'b0}}, b_mem_addr} : {DW{1'bz}};

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) dut_b (
    .CLK(clk), .RST(rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .MEM_CS(b_mem_cs), .MEM_WE(b_mem_we), .MEM_ADDR(b_mem_addr), .MEM_BUS(b_mem_bus),
    .gcnt0(b_gcnt0), .gcnt1(b_gcnt1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    tb_drv = 0; tb_drv_val = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  // One transaction on dut_a. Called in an IDLE cycle at posedge+1; returns
  // in the IDLE cycle after the ack. Command inputs are scrambled once ACC is
  // reached, so only the latched copy may reach the memory.
  task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    int   lat;
    int   cs_cyc;
    logic other_ack;
    lat = -1; cs_cyc = 0; other_ack = 1'b0; rd = '0;
    if (port == P0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else            begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (mem_cs) begin
        cs_cyc++;
        check("acc_addr", 32'(mem_addr), 32'(addr));
        check("acc_we", 32'(mem_we), 32'(we));
        if (port == P0) begin addr0 = ~addr; wdata0 = ~wd; we0 = ~we; end
        else            begin addr1 = ~addr; wdata1 = ~wd; we1 = ~we; end
      end
      if ((port == P0) ? ack1 : ack0) other_ack = 1'b1;
      if ((port == P0) ? ack0 : ack1) begin
        lat = n;
        rd  = (port == P0) ? rdata0 : rdata1;
        break;
      end
    end
    if (port == P0) req0 = 0; else req1 = 0;
    tick();
    check("ack_latency", 32'(lat), 32'd2);
    check("cs_cycles", 32'(cs_cyc), 32'd1);
    check("no_cross_ack", 32'(other_ack), 32'd0);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;   // port's rdata after the access (held on writes)
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    int            k;
    int            k0;
    logic          overlap;
    logic          early1;
    logic          got1;
    int            ack1_cyc;
    int            ord [8];
    int            cyc [8];

    // ---- reset state ----
    clear_inputs();
    rst = 0;
    tb_drv = 1; tb_drv_val = 32'h0F0F_1234;
    #2;
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_bus_released", mem_bus, 32'h0F0F_1234);
    check("rst_gcnt0", 32'(gcnt0), 32'd0);
    check("rst_gcnt1", 32'(gcnt1), 32'd0);
    tb_drv = 0;
    tick();
    rst = 1;
    tick();

    // ---- prefill addresses used by the tie test ----
    do_txn(P0, 1'b1, 7'd3, 32'h0000_3333, rd);
    check("prefill_rdata0_held", rd, 32'd0);
    do_txn(P1, 1'b1, 7'd4, 32'h0000_4444, rd);
    check("prefill_rdata1_held", rd, 32'd0);

    // ---- tie from reset: port 0 first, then port 1 ----
    do_reset();
    req0 = 1; we0 = 0; addr0 = 7'd3;
    req1 = 1; we1 = 0; addr1 = 7'd4;
    k = 0; overlap = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ack0 && ack1) overlap = 1;
      if (ack0 && k < 8) begin ord[k] = 0; k++; req0 = 0; end
      if (ack1 && k < 8) begin ord[k] = 1; k++; req1 = 0; end
      if (k >= 2) break;
    end
    req0 = 0; req1 = 0;
    tick();
    check("tie_count", 32'(k), 32'd2);
    check("tie_first", 32'(ord[0]), 32'd0);
    check("tie_second", 32'(ord[1]), 32'd1);
    check("tie_no_overlap", 32'(overlap), 32'd0);
    check("tie_rdata0", rdata0, 32'h0000_3333);
    check("tie_rdata1", rdata1, 32'h0000_4444);

    // ---- table of single-port transactions ----
    vecs[0] = '{P0, 1'b1, 7'd7,   32'h1234_5678, 32'h0000_3333};
    vecs[1] = '{P1, 1'b0, 7'd7,   32'h0000_0000, 32'h1234_5678};
    vecs[2] = '{P1, 1'b1, 7'd3,   32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{P0, 1'b0, 7'd3,   32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4] = '{P0, 1'b1, 7'd0,   32'hA5A5_0F0F, 32'hDEAD_BEEF};
    vecs[5] = '{P1, 1'b1, 7'd127, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[6] = '{P0, 1'b0, 7'd127, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{P1, 1'b0, 7'd0,   32'h0000_0000, 32'hA5A5_0F0F};
    vecs[8] = '{P0, 1'b0, 7'd7,   32'h0000_0000, 32'h1234_5678};
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // ---- round-robin fairness: both requesting continuously ----
    do_reset();
    req0 = 1; we0 = 0; addr0 = 7'd1;
    req1 = 1; we1 = 0; addr1 = 7'd2;
    k = 0; overlap = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack0 && ack1) overlap = 1;
      if (ack0 && k < 8) begin ord[k] = 0; cyc[k] = n; k++; end
      if (ack1 && k < 8) begin ord[k] = 1; cyc[k] = n; k++; end
      if (k >= 6) break;
    end
    req0 = 0; req1 = 0;
    tick(); tick();
    check("rr_count", 32'(k), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(i % 2));
    check("rr_no_overlap", 32'(overlap), 32'd0);
    check("rr_last_ack_cycle", 32'(cyc[5]), 32'd17);

    // ---- fixed priority on dut_b ----
    do_reset();
    b_req0 = 1; b_we0 = 0; b_addr0 = 7'd5;
    b_req1 = 1; b_we1 = 0; b_addr1 = 7'd6;
    k0 = 0; early1 = 0; got1 = 0; ack1_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (b_ack1 && k0 < 4) early1 = 1;
      if (b_ack1) begin got1 = 1; ack1_cyc = n; b_req1 = 0; break; end
      if (b_ack0) begin
        k0++;
        if (k0 >= 4) b_req0 = 0;
      end
    end
    b_req0 = 0; b_req1 = 0;
    tick();
    check("fp_port0_grants", 32'(k0), 32'd4);
    check("fp_no_early_ack1", 32'(early1), 32'd0);
    check("fp_port1_served", 32'(got1), 32'd1);
    check("fp_ack1_cycle", 32'(ack1_cyc), 32'd14);
    check("fp_rdata0", b_rdata0, 32'd5);
    check("fp_rdata1", b_rdata1, 32'd6);

    // ---- reset during a port-1 write ACC cycle ----
    req1 = 1; we1 = 1; addr1 = 7'd9; wdata1 = 32'hCAFE_F00D;
    tick();
    check("abort_acc_cs", 32'(mem_cs), 32'd1);
    rst = 0;
    #1;
    check("abort_cs", 32'(mem_cs), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    tb_drv = 1; tb_drv_val = 32'h5A5A_C3C3;
    #1;
    check("abort_bus_released", mem_bus, 32'h5A5A_C3C3);
    tb_drv = 0;
    req1 = 0; we1 = 0;
    tick();
    check("abort_no_ack1_a", 32'(ack1), 32'd0);
    tick();
    check("abort_no_ack1_b", 32'(ack1), 32'd0);
    rst = 1;
    tick();
    check("abort_idle_ack1", 32'(ack1), 32'd0);
    do_txn(P0, 1'b0, 7'd7, 32'h0, rd);
    check("post_abort_read", rd, 32'h1234_5678);

    // ---- grant counters ----
    do_reset();
    for (int i = 0; i < 5; i++) do_txn(P0, 1'b0, 7'(i), 32'h0, rd);
    for (int i = 0; i < 2; i++) do_txn(P1, 1'b0, 7'(i), 32'h0, rd);
`ifdef MEM_ARB_STATS_EN
    check("gcnt0", 32'(gcnt0), 32'd5);
    check("gcnt1", 32'(gcnt1), 32'd2);
`else
    check("gcnt0_tied", 32'(gcnt0), 32'd0);
    check("gcnt1_tied", 32'(gcnt1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
